countdown_timer_mmss: RTL and testbench

- Down-counting mm:ss timer; the countdown counterpart of the stopwatch's up-counting seconds/minutes chain.
- Driven by the shared 1 Hz tick strobe.
- Loaded with a preset value, started, paused and cleared by button-derived single-cycle pulses.
- Signals expiry to the alarm/display logic through a level flag and a one-cycle pulse.

---
 rtl/countdown_timer_mmss.sv | 169 ++++++++++++++++
 tb/tb_countdown_timer_mmss.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss: mm:ss down-counter paced by a shared 1 Hz tick strobe.
// Latency: every effect is registered and appears one cycle after its cause.
// Backpressure: none; control pulses are consumed in the cycle they arrive.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   tick                       1 Hz strobe, counted only while running
//   load, load_min, load_sec   capture a preset (rejected if out of range)
//   start, stop, clear         control pulses (priority: clear > load > stop > start > tick)
//   minutes, seconds           current count
//   running, expired           state flags (RUN, DONE)
//   expire_pulse, load_err     one-cycle event strobes
//
// Build option: define COUNTDOWN_AUTO_RELOAD_EN to reload the preset on expiry
// and keep running instead of stopping in DONE.
module countdown_timer_mmss #(
  parameter int MAX_MIN = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [6:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [6:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       expired,
  output logic       expire_pulse,
  output logic       load_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [6:0] MaxMin = 7'(MAX_MIN);

  state_t     state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       run_q, run_d;
  logic       exp_q, exp_d;
  logic       ep_q, ep_d;
  logic       le_q, le_d;

  logic load_ok;
  logic at_one;
  logic count_zero;

  assign load_ok    = (load_sec <= 6'd59) && (load_min <= MaxMin);
  assign at_one     = (min_q == 7'd0) && (sec_q == 6'd1);
  assign count_zero = (min_q == 7'd0) && (sec_q == 6'd0);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  // The preset is only observable through the reload path.
  logic [6:0] pmin_q, pmin_d;
  logic [5:0] psec_q, psec_d;
  logic       preset_zero;
  assign preset_zero = (pmin_q == 7'd0) && (psec_q == 6'd0);
`endif

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ep_d    = 1'b0;
    le_d    = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    pmin_d  = pmin_q;
    psec_d  = psec_q;
`endif

    if (clear) begin
      state_d = S_IDLE;
      min_d   = 7'd0;
      sec_d   = 6'd0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      pmin_d  = 7'd0;
      psec_d  = 6'd0;
`endif
    end else if (load) begin
      if (load_ok) begin
        state_d = S_IDLE;
        min_d   = load_min;
        sec_d   = load_sec;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        pmin_d  = load_min;
        psec_d  = load_sec;
`endif
      end else begin
        le_d = 1'b1;
      end
    end else if (stop) begin
      if (state_q == S_RUN) state_d = S_PAUSE;
    end else if (start) begin
      // A tick in the same cycle is deliberately dropped: counting begins
      // with the first tick seen after RUN is entered.
      if ((state_q == S_PAUSE) || ((state_q == S_IDLE) && !count_zero)) begin
        state_d = S_RUN;
      end
    end else if (tick && (state_q == S_RUN)) begin
      if (sec_q != 6'd0) begin
        sec_d = sec_q - 6'd1;
      end else if (min_q != 7'd0) begin
        // Borrow: taken only when minutes > 0, so minutes never wraps.
        min_d = min_q - 7'd1;
        sec_d = 6'd59;
      end
      if (at_one) begin
        ep_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (!preset_zero) begin
          min_d = pmin_q;
          sec_d = psec_q;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
    end

    run_d = (state_d == S_RUN);
    exp_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      min_q   <= 7'd0;
      sec_q   <= 6'd0;
      run_q   <= 1'b0;
      exp_q   <= 1'b0;
      ep_q    <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      run_q   <= run_d;
      exp_q   <= exp_d;
      ep_q    <= ep_d;
      le_q    <= le_d;
    end
  end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmin_q <= 7'd0;
      psec_q <= 6'd0;
    end else begin
      pmin_q <= pmin_d;
      psec_q <= psec_d;
    end
  end
`endif

  assign minutes      = min_q;
  assign seconds      = sec_q;
  assign running      = run_q;
  assign expired      = exp_q;
  assign expire_pulse = ep_q;
  assign load_err     = le_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb_countdown_timer_mmss: table of directed cycles, hand-written corner
// sequences, then randomized traffic checked against a seconds-total model.
module tb_countdown_timer_mmss;

  localparam int MAXM = 99;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       stop;
  logic       clear;
  logic [6:0] minutes;
  logic [5:0] seconds;
  logic       running;
  logic       expired;
  logic       expire_pulse;
  logic       load_err;

  countdown_timer_mmss #(.MAX_MIN(MAXM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .load         (load),
    .load_min     (load_min),
    .load_sec     (load_sec),
    .start        (start),
    .stop         (stop),
    .clear        (clear),
    .minutes      (minutes),
    .seconds      (seconds),
    .running      (running),
    .expired      (expired),
    .expire_pulse (expire_pulse),
    .load_err     (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: the count is a plain number of seconds; state is
  // 0=idle 1=run 2=pause 3=done.
  int m_cnt = 0;
  int m_pre = 0;
  int m_st  = 0;
  bit m_ep  = 0;
  bit m_le  = 0;

  typedef struct {
    logic       r, c, l;
    logic [6:0] lm;
    logic [5:0] ls;
    logic       s, p, t;
    logic [16:0] e;
  } vec_t;

  vec_t vq[$];

  wire [16:0] dv = {minutes, seconds, running, expired, expire_pulse, load_err};

  function automatic logic [16:0] mk(input int mm, input int ss, input bit rn,
                                     input bit ex, input bit ep, input bit le);
    return {7'(mm), 6'(ss), rn, ex, ep, le};
  endfunction

  function automatic logic [16:0] model_vec();
    return mk(m_cnt / 60, m_cnt % 60, m_st == 1, m_st == 3, m_ep, m_le);
  endfunction

  task automatic model_step(input logic r, c, l, input logic [6:0] lm,
                            input logic [5:0] ls, input logic s, p, t);
    m_ep = 0;
    m_le = 0;
    if (!r) begin
      m_cnt = 0; m_pre = 0; m_st = 0;
    end else if (c) begin
      m_cnt = 0; m_pre = 0; m_st = 0;
    end else if (l) begin
      if (int'(ls) > 59 || int'(lm) > MAXM) m_le = 1;
      else begin
        m_cnt = int'(lm) * 60 + int'(ls);
        m_pre = m_cnt;
        m_st  = 0;
      end
    end else if (p) begin
      if (m_st == 1) m_st = 2;
    end else if (s) begin
      if ((m_st == 0 && m_cnt != 0) || m_st == 2) m_st = 1;
    end else if (t && m_st == 1) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_ep = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        if (m_pre != 0) m_cnt = m_pre;
        else m_st = 3;
`else
        m_st = 3;
`endif
      end
    end
  endtask

  task automatic cyc(input logic r, c, l, input logic [6:0] lm,
                     input logic [5:0] ls, input logic s, p, t);
    rst_n = r; clear = c; load = l; load_min = lm; load_sec = ls;
    start = s; stop = p; tick = t;
    model_step(r, c, l, lm, ls, s, p, t);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [16:0] got, input logic [16:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got mm=%0d ss=%0d run=%b exp=%b ep=%b le=%b want mm=%0d ss=%0d run=%b exp=%b ep=%b le=%b",
               nm, got[16:10], got[9:4], got[3], got[2], got[1], got[0],
               want[16:10], want[9:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  task automatic add(input logic r, c, l, input logic [6:0] lm, input logic [5:0] ls,
                     input logic s, p, t, input logic [16:0] e);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.lm = lm; v.ls = ls;
    v.s = s; v.p = p; v.t = t; v.e = e;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; load = 1'b0; load_min = 7'd0; load_sec = 6'd0;
    start = 1'b0; stop = 1'b0; tick = 1'b0;

    //   r  c  l  lm      ls      s  p  t   expected mm ss run exp ep le
    add(0, 0, 0, 7'd0,   6'd0,   0, 0, 0, mk(0,  0, 0, 0, 0, 0)); // reset
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0,  0, 0, 0, 0, 0)); // start at 00:00 ignored
    add(1, 0, 1, 7'd0,   6'd60,  0, 0, 0, mk(0,  0, 0, 0, 0, 1)); // sec 60 rejected
    add(1, 0, 1, 7'd100, 6'd0,   0, 0, 0, mk(0,  0, 0, 0, 0, 1)); // min 100 rejected
    add(1, 0, 1, 7'd99,  6'd59,  0, 0, 0, mk(99, 59, 0, 0, 0, 0)); // max accepted
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 0, mk(99, 59, 0, 0, 0, 0)); // load_err one cycle
    add(1, 1, 1, 7'd1,   6'd0,   0, 0, 0, mk(0,  0, 0, 0, 0, 0)); // clear beats load
    add(1, 0, 1, 7'd0,   6'd5,   0, 0, 0, mk(0,  5, 0, 0, 0, 0));
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 1, mk(0,  5, 1, 0, 0, 0)); // start+tick: no dec
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  4, 1, 0, 0, 0));
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  3, 1, 0, 0, 0));
    add(1, 0, 0, 7'd0,   6'd0,   1, 1, 0, mk(0,  3, 0, 0, 0, 0)); // stop beats start
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  3, 0, 0, 0, 0)); // tick in pause
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0,  3, 1, 0, 0, 0)); // resume
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  2, 1, 0, 0, 0));
    add(1, 0, 1, 7'd0,   6'd30,  0, 0, 1, mk(0, 30, 0, 0, 0, 0)); // load while running
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0, 30, 1, 0, 0, 0));
    add(1, 0, 0, 7'd0,   6'd0,   0, 1, 1, mk(0, 30, 0, 0, 0, 0)); // stop+tick: no dec
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0, 30, 1, 0, 0, 0));
    add(1, 0, 1, 7'd0,   6'd1,   0, 0, 0, mk(0,  1, 0, 0, 0, 0));
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0,  1, 1, 0, 0, 0));
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  1, 1, 0, 1, 0)); // expire, reload
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  1, 1, 0, 1, 0));
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0,  1, 1, 0, 0, 0));
`else
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  0, 0, 1, 1, 0)); // expire
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  0, 0, 1, 0, 0)); // hold in DONE
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0,  0, 0, 1, 0, 0)); // start ignored
`endif
    add(1, 1, 0, 7'd0,   6'd0,   0, 0, 0, mk(0,  0, 0, 0, 0, 0)); // clear
    add(1, 0, 1, 7'd0,   6'd1,   0, 0, 0, mk(0,  1, 0, 0, 0, 0));
    add(1, 0, 0, 7'd0,   6'd0,   1, 0, 0, mk(0,  1, 1, 0, 0, 0));
    add(0, 0, 0, 7'd0,   6'd0,   0, 0, 1, mk(0,  0, 0, 0, 0, 0)); // reset beats expiry
    add(1, 0, 0, 7'd0,   6'd0,   0, 0, 0, mk(0,  0, 0, 0, 0, 0));

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].c, vq[i].l, vq[i].lm, vq[i].ls, vq[i].s, vq[i].p, vq[i].t);
      chk($sformatf("vec%0d", i), dv, vq[i].e);
    end

    // 01:02 run down to zero, one tick per cycle.
    cyc(1, 1, 0, 7'd0, 6'd0, 0, 0, 0);
    cyc(1, 0, 1, 7'd1, 6'd2, 0, 0, 0);
    chk("load_0102", dv, mk(1, 2, 0, 0, 0, 0));
    cyc(1, 0, 0, 7'd0, 6'd0, 1, 0, 0);
    chk("start_0102", dv, mk(1, 2, 1, 0, 0, 0));
    for (int k = 1; k <= 62; k++) begin
      int tot;
      cyc(1, 0, 0, 7'd0, 6'd0, 0, 0, 1);
      tot = 62 - k;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      if (tot == 0) chk("rundown_end", dv, mk(1, 2, 1, 0, 1, 0));
      else chk($sformatf("rundown_%0d", k), dv, mk(tot / 60, tot % 60, 1, 0, 0, 0));
`else
      if (tot == 0) chk("rundown_end", dv, mk(0, 0, 0, 1, 1, 0));
      else chk($sformatf("rundown_%0d", k), dv, mk(tot / 60, tot % 60, 1, 0, 0, 0));
`endif
    end
    cyc(1, 0, 0, 7'd0, 6'd0, 0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    chk("after_end", dv, mk(1, 2, 1, 0, 0, 0));
`else
    chk("after_end", dv, mk(0, 0, 0, 1, 0, 0));
`endif

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // 00:03 with seven ticks: reload after tick 3, 00:02 after tick 7.
    cyc(1, 1, 0, 7'd0, 6'd0, 0, 0, 0);
    cyc(1, 0, 1, 7'd0, 6'd3, 0, 0, 0);
    cyc(1, 0, 0, 7'd0, 6'd0, 1, 0, 0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1, 0, 0, 7'd0, 6'd0, 0, 0, 1);
      if (k == 3) chk("reload_t3", dv, mk(0, 3, 1, 0, 1, 0));
      if (k == 7) chk("reload_t7", dv, mk(0, 2, 1, 0, 0, 0));
    end
`endif

    // Randomized traffic against the model.
    cyc(0, 0, 0, 7'd0, 6'd0, 0, 0, 0);
    chk("rand_reset", dv, model_vec());
    for (int n = 0; n < 4000; n++) begin
      logic r, c, l, s, p, t;
      logic [6:0] lm;
      logic [5:0] ls;
      r  = ($urandom_range(0, 299) != 0);
      c  = ($urandom_range(0, 79) == 0);
      l  = ($urandom_range(0, 24) == 0);
      lm = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 1));
      ls = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 8));
      s  = ($urandom_range(0, 7) == 0);
      p  = ($urandom_range(0, 19) == 0);
      t  = ($urandom_range(0, 1) == 1);
      cyc(r, c, l, lm, ls, s, p, t);
      chk($sformatf("rand%0d", n), dv, model_vec());
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
